mem_burst_ctrl: RTL and testbench
=================================

MEM_BURST_CTRL -- requirements
Module: mem_burst_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_W, 5, memory word address width; DATA_W, 16, memory word width.
REQ-002 Port list SHALL be, clock and reset first (name, direction, width, meaning):
- CLK, in, 1: single clock, all logic on posedge.
- RST_N, in, 1: asynchronous active-low reset.
- REQ_VALID, in, 1: burst request valid.
- REQ_READY, out, 1: controller accepts request.
- REQ_WRITE, in, 1: 1 = write burst, 0 = read burst.
- REQ_ADDR, in, ADDR_W: burst start address.
- REQ_LEN, in, ADDR_W+1: burst length in words, 0..32.
- WR_DATA, in, DATA_W: write beat data.
- WR_VALID, in, 1: write beat valid.
- WR_READY, out, 1: write beat accepted.
- RD_DATA, out, DATA_W: read beat data.
- RD_VALID, out, 1: read beat valid; no backpressure.
- BUSY, out, 1: burst in progress.
- DONE, out, 1: one-cycle burst completion pulse.
- MRD, out, 1: memory read strobe.
- MWR, out, 1: memory write strobe.
- ADDR, out, ADDR_W: memory word address.
- DATA_OUT, out, DATA_W: write data to the shared memory data bus.
- DATA_OE, out, 1: DATA_OUT drive enable on the shared bus.
- DATA_IN, in, DATA_W: shared memory data bus as read back.

Function
REQ-003 The block SHALL act as the initiator on the memory interface. The responder captures DATA at a posedge where MWR=1, and loads DATA from MEM[ADDR] at a posedge where MRD=1.
REQ-004 MRD, MWR, ADDR, DATA_OUT, DATA_OE, RD_DATA, RD_VALID, DONE and BUSY SHALL all be registered outputs.
REQ-005 The FSM SHALL have the states IDLE, WRITE, WFLUSH, READ and RDRAIN.
REQ-006 REQ_READY SHALL be 1 only in IDLE. A request is accepted on a posedge with REQ_VALID & REQ_READY; the block latches REQ_ADDR into a current-address register and REQ_LEN into a remaining count.
REQ-007 An accepted request with REQ_LEN=0 SHALL pulse DONE in the next cycle, stay in IDLE and assert no MRD/MWR.
REQ-008 A nonzero request SHALL go to WRITE if REQ_WRITE=1, else to READ. BUSY SHALL be 1 from the cycle after acceptance through the DONE cycle inclusive.
REQ-009 WRITE: WR_READY=1 throughout.
- Each WR_VALID handshake: next cycle drives MWR=1, DATA_OE=1, ADDR=current, DATA_OUT=WR_DATA; current increments, count decrements.
- Cycles without a handshake: next cycle drives MWR=0, DATA_OE=0.
REQ-010 On the handshake of the last write beat, the FSM SHALL move to WFLUSH, which carries the final MWR cycle. The FSM then returns to IDLE with DONE=1 in the cycle immediately after the final MWR cycle.
REQ-011 READ: one read SHALL be issued per cycle, unconditionally (MRD=1, ADDR=current, then increment/decrement). After the last issue the FSM moves to RDRAIN.
REQ-012 Read data SHALL be sampled from DATA_IN exactly two cycles after the corresponding MRD cycle and presented as RD_DATA with RD_VALID=1. Beats are delivered in address order, one per cycle, with no gaps.
REQ-013 DONE SHALL coincide with the last RD_VALID. The FSM leaves RDRAIN for IDLE in that cycle.
REQ-014 Read timing for a length-L burst accepted at edge e0 SHALL be: MRD high in cycles 1..L, RD_VALID high in cycles 3..L+2, DONE in cycle L+2.
REQ-015 Address arithmetic SHALL be modulo 2^ADDR_W: address 31 wraps to 0 within a burst.
REQ-016 MRD and MWR SHALL never be 1 in the same cycle. DATA_OE SHALL equal MWR every cycle.
REQ-017 In cycles with MRD=0 and MWR=0, ADDR and DATA_OUT SHALL hold their last values.
REQ-018 REQ_VALID outside IDLE SHALL be ignored (held off by REQ_READY=0). WR_VALID outside WRITE SHALL be ignored.
REQ-019 Simultaneous completion and a new request SHALL be handled as follows: a request presented in the DONE cycle is accepted only once REQ_READY=1, i.e. no earlier than the cycle after DONE.

Reset
REQ-020 While RST_N=0 the block SHALL hold the FSM in IDLE, with BUSY, DONE, MRD, MWR, DATA_OE, RD_VALID, WR_READY=0; ADDR, DATA_OUT, RD_DATA=0; count=0; REQ_READY=0.
REQ-021 After RST_N rises, REQ_READY SHALL be 1 from the first posedge.
REQ-022 Reset asserted mid-burst SHALL abort the burst immediately and asynchronously: strobes drop without waiting for a clock, no DONE is produced, and in-flight read beats are discarded.

Verification
REQ-023 Write: LEN=4, ADDR=3, WR_VALID held 1 with data A0..A3 -> MWR high for 4 consecutive cycles at ADDR 3,4,5,6; DONE one cycle after the last MWR; MEM[3..6]=A0..A3.
REQ-024 Read-back: read LEN=4, ADDR=3 of the above -> MRD cycles 1-4; RD_VALID cycles 3-6 with A0..A3; DONE in cycle 6.
REQ-025 Wrap: write LEN=3 at ADDR=30 -> ADDR sequence 30,31,0; the following read returns the same data in order.
REQ-026 Stalled write: WR_VALID toggling 1,0,0,1 for LEN=2 -> exactly two MWR cycles, separated by two idle cycles; DONE after the second.
REQ-027 Corner requests: LEN=0 -> DONE the next cycle, no strobes. A request held during BUSY -> not accepted until the cycle after DONE.
REQ-028 Reset mid-burst: RST_N low during cycle 2 of a LEN=8 read -> MRD/RD_VALID/BUSY 0 at once; no DONE; REQ_READY=1 one edge after release.

Source files
------------

// File: rtl/mem_burst_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_burst_ctrl_if
//  Purpose  : Bundles the request, write-beat, read-beat and memory-side
//             signals of mem_burst_ctrl into one interface.
//  Ports    : REQ_VALID/REQ_READY/REQ_WRITE/REQ_ADDR/REQ_LEN - burst request
//             WR_DATA/WR_VALID/WR_READY                      - write beats
//             RD_DATA/RD_VALID                               - read beats
//             BUSY/DONE                                      - burst status
//             MRD/MWR/ADDR/DATA_OUT/DATA_OE/DATA_IN          - memory side
//  Modports : master - requester plus memory responder (drives the inputs)
//             slave  - the burst controller
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_burst_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
);
  logic              REQ_VALID;
  logic              REQ_READY;
  logic              REQ_WRITE;
  logic [ADDR_W-1:0] REQ_ADDR;
  logic [ADDR_W:0]   REQ_LEN;
  logic [DATA_W-1:0] WR_DATA;
  logic              WR_VALID;
  logic              WR_READY;
  logic [DATA_W-1:0] RD_DATA;
  logic              RD_VALID;
  logic              BUSY;
  logic              DONE;
  logic              MRD;
  logic              MWR;
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] DATA_OUT;
  logic              DATA_OE;
  logic [DATA_W-1:0] DATA_IN;

  modport master (
    output REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_LEN, WR_DATA, WR_VALID, DATA_IN,
    input  REQ_READY, WR_READY, RD_DATA, RD_VALID, BUSY, DONE,
           MRD, MWR, ADDR, DATA_OUT, DATA_OE
  );

  modport slave (
    input  REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_LEN, WR_DATA, WR_VALID, DATA_IN,
    output REQ_READY, WR_READY, RD_DATA, RD_VALID, BUSY, DONE,
           MRD, MWR, ADDR, DATA_OUT, DATA_OE
  );
endinterface
`default_nettype wire

// File: rtl/mem_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_burst_ctrl
//  Purpose  : Burst initiator for a simple synchronous word memory. Accepts a
//             burst request (start address, length 0..32, direction), issues
//             one memory strobe per beat with wrapping addresses, and returns
//             read data two cycles after each read strobe.
//  Ports    : CLK   - clock, all logic on posedge
//             RST_N - asynchronous active-low reset
//             bus   - mem_burst_ctrl_if.slave (request, beat and memory signals)
//  Revision : 1.0 - initial release
// ============================================================================
module mem_burst_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input wire             CLK,
  input wire             RST_N,
  mem_burst_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    WFLUSH = 3'd2,
    READ   = 3'd3,
    RDRAIN = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   c_cnt_one  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   c_cnt_zero = '0;

  state_t            state_q,    state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W:0]   cnt_q,      cnt_d;
  logic              mrd_q,      mrd_d;
  logic              mwr_q,      mwr_d;
  logic              data_oe_q,  data_oe_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              rd_pipe_q,  rd_pipe_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q,  rd_data_d;
  logic              done_q,     done_d;
  logic              busy_q,     busy_d;
  logic              req_ready_q, req_ready_d;
  logic              wr_ready_q,  wr_ready_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      cnt_q       <= '0;
      mrd_q       <= 1'b0;
      mwr_q       <= 1'b0;
      data_oe_q   <= 1'b0;
      addr_q      <= '0;
      data_out_q  <= '0;
      rd_pipe_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      req_ready_q <= 1'b0;
      wr_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      cnt_q       <= cnt_d;
      mrd_q       <= mrd_d;
      mwr_q       <= mwr_d;
      data_oe_q   <= data_oe_d;
      addr_q      <= addr_d;
      data_out_q  <= data_out_d;
      rd_pipe_q   <= rd_pipe_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      req_ready_q <= req_ready_d;
      wr_ready_q  <= wr_ready_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    cnt_d      = cnt_q;
    mrd_d      = 1'b0;
    mwr_d      = 1'b0;
    data_oe_d  = 1'b0;
    addr_d     = addr_q;
    data_out_d = data_out_q;
    done_d     = 1'b0;

    // Read return path: the responder loads DATA_IN at the edge closing an
    // MRD cycle, so the data is on DATA_IN one cycle after MRD and is
    // registered into RD_DATA for presentation two cycles after MRD.
    rd_pipe_d  = mrd_q;
    rd_valid_d = rd_pipe_q;
    rd_data_d  = rd_pipe_q ? bus.DATA_IN : rd_data_q;

    case (state_q)
      IDLE: begin
        if (bus.REQ_VALID && req_ready_q) begin
          cur_addr_d = bus.REQ_ADDR;
          cnt_d      = bus.REQ_LEN;
          if (bus.REQ_LEN == c_cnt_zero) begin
            done_d = 1'b1;
          end else if (bus.REQ_WRITE) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end

      WRITE: begin
        if (bus.WR_VALID && wr_ready_q) begin
          mwr_d      = 1'b1;
          data_oe_d  = 1'b1;
          addr_d     = cur_addr_q;
          data_out_d = bus.WR_DATA;
          cur_addr_d = cur_addr_q + c_addr_one;
          cnt_d      = cnt_q - c_cnt_one;
          if (cnt_q == c_cnt_one) begin
            state_d = WFLUSH;
          end
        end
      end

      // The final MWR is on the bus during this state; completion follows.
      WFLUSH: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end

      READ: begin
        mrd_d      = 1'b1;
        addr_d     = cur_addr_q;
        cur_addr_d = cur_addr_q + c_addr_one;
        cnt_d      = cnt_q - c_cnt_one;
        if (cnt_q == c_cnt_one) begin
          state_d = RDRAIN;
        end
      end

      // The last beat sits in the first pipe stage once no strobe is left
      // behind it; it becomes RD_VALID together with DONE.
      RDRAIN: begin
        if (rd_pipe_q && !mrd_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // BUSY covers the completion cycle of a real burst; a zero-length
    // request completes without ever leaving IDLE and never raises BUSY.
    busy_d      = (state_d != IDLE) || (done_d && (state_q != IDLE));
    // Ready is held low during the DONE cycle so a waiting request is taken
    // no earlier than the cycle after completion.
    req_ready_d = (state_d == IDLE) && !done_d;
    wr_ready_d  = (state_d == WRITE);
  end

  assign bus.REQ_READY = req_ready_q;
  assign bus.WR_READY  = wr_ready_q;
  assign bus.RD_DATA   = rd_data_q;
  assign bus.RD_VALID  = rd_valid_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.MRD       = mrd_q;
  assign bus.MWR       = mwr_q;
  assign bus.ADDR      = addr_q;
  assign bus.DATA_OUT  = data_out_q;
  assign bus.DATA_OE   = data_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_burst_ctrl
//  Purpose  : Scoreboard bench for mem_burst_ctrl. Stimulus tasks push the
//             expected memory strobes, read beats and DONE cycles (derived
//             from a word-array model of memory and the burst timing rules)
//             into queues; a negedge monitor pops and compares them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_burst_ctrl;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NEVER  = 1000000;

  logic CLK   = 1'b0;
  logic RST_N = 1'b1;
  always #5 CLK = ~CLK;

  mem_burst_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_burst_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] init_val(input int i);
    return DATA_W'((i * 16'h1357) ^ 16'hA5A5);
  endfunction

  // Memory responder: writes on MWR edges, loads DATA_IN on MRD edges.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] din_r    = '0;
  logic              mem_init = 1'b0;
  always @(posedge CLK) begin
    if (!mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
      mem_init <= 1'b1;
    end else begin
      if (bus.MWR) mem[bus.ADDR] <= bus.DATA_OUT;
      if (bus.MRD) din_r <= mem[bus.ADDR];
    end
  end
  assign bus.DATA_IN = din_r;

  // Reference model state
  logic [DATA_W-1:0] refmem [DEPTH];
  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } beat_t;
  beat_t wq[$];
  beat_t mrq[$];
  beat_t rq[$];
  int    dq[$];
  int    idle_from = 0;
  int    busy_lo   = 1;
  int    busy_hi   = 0;
  bit    mon_en    = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [DATA_W-1:0] prev_do   = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor / scoreboard
  always @(negedge CLK) begin
    beat_t e;
    if (mon_en && RST_N) begin
      chk("mrd_mwr_exclusive", bus.MRD & bus.MWR, 0);
      chk("data_oe_eq_mwr", bus.DATA_OE, bus.MWR);
      chk("busy", bus.BUSY, (cyc >= busy_lo) && (cyc <= busy_hi));
      chk("req_ready", bus.REQ_READY, cyc >= idle_from);

      if (bus.MWR) begin
        if (wq.size() == 0) fail_now("unexpected_mwr");
        else begin
          e = wq.pop_front();
          chk("mwr_cycle", cyc, e.cyc);
          chk("mwr_addr", bus.ADDR, e.addr);
          chk("mwr_data", bus.DATA_OUT, e.data);
        end
      end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
        fail_now("missing_mwr");
        void'(wq.pop_front());
      end

      if (bus.MRD) begin
        if (mrq.size() == 0) fail_now("unexpected_mrd");
        else begin
          e = mrq.pop_front();
          chk("mrd_cycle", cyc, e.cyc);
          chk("mrd_addr", bus.ADDR, e.addr);
        end
      end else if (mrq.size() > 0 && mrq[0].cyc <= cyc) begin
        fail_now("missing_mrd");
        void'(mrq.pop_front());
      end

      if (bus.RD_VALID) begin
        if (rq.size() == 0) fail_now("unexpected_rd_valid");
        else begin
          e = rq.pop_front();
          chk("rd_cycle", cyc, e.cyc);
          chk("rd_data", bus.RD_DATA, e.data);
        end
      end else if (rq.size() > 0 && rq[0].cyc <= cyc) begin
        fail_now("missing_rd_valid");
        void'(rq.pop_front());
      end

      if (bus.DONE) begin
        if (dq.size() == 0) fail_now("unexpected_done");
        else chk("done_cycle", cyc, dq.pop_front());
      end else if (dq.size() > 0 && dq[0] <= cyc) begin
        fail_now("missing_done");
        void'(dq.pop_front());
      end

      if (!bus.MRD && !bus.MWR) begin
        chk("addr_hold", bus.ADDR, prev_addr);
        chk("data_out_hold", bus.DATA_OUT, prev_do);
      end
      prev_addr = bus.ADDR;
      prev_do   = bus.DATA_OUT;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Waits until the model says the controller is idle; write-beat inputs
  // wiggle meanwhile and must be ignored outside WRITE.
  task automatic wait_idle();
    int guard = 0;
    while (cyc < idle_from && guard < 200) begin
      bus.WR_VALID = 1'($urandom_range(0, 1));
      bus.WR_DATA  = DATA_W'($urandom);
      step();
      guard++;
    end
    if (cyc < idle_from) fail_now("wait_idle_timeout");
  endtask

  task automatic issue(input bit wr, input int addr, input int len, output int c0);
    wait_idle();
    chk("req_ready_at_issue", bus.REQ_READY, 1);
    bus.REQ_VALID = 1'b1;
    bus.REQ_WRITE = wr;
    bus.REQ_ADDR  = ADDR_W'(addr);
    bus.REQ_LEN   = (ADDR_W+1)'(len);
    step();
    c0 = cyc;
    bus.REQ_VALID = 1'b0;
    bus.REQ_ADDR  = ADDR_W'($urandom);
    bus.REQ_LEN   = (ADDR_W+1)'($urandom);
    idle_from     = NEVER;
  endtask

  function automatic logic [ADDR_W-1:0] wrap(input int a, input int n);
    return ADDR_W'((a + n) % DEPTH);
  endfunction

  // mode 0: WR_VALID held high; 1: random; 2: pattern 1,0,0,1 then high
  task automatic write_burst(input int addr, input int len, input int mode);
    int c0, c, n, j;
    bit v;
    beat_t b;
    logic [DATA_W-1:0] d;
    issue(1'b1, addr, len, c0);
    if (len == 0) begin
      dq.push_back(c0);
      idle_from = c0 + 1;
      return;
    end
    busy_lo = c0;
    busy_hi = NEVER;
    n = 0;
    j = 0;
    while (n < len) begin
      c = cyc;
      case (mode)
        0:       v = 1'b1;
        1:       v = ($urandom_range(0, 2) != 0);
        default: v = (j == 0) || (j >= 3);
      endcase
      d = DATA_W'($urandom);
      bus.WR_VALID = v;
      bus.WR_DATA  = d;
      if (v) begin
        b.cyc  = c + 1;
        b.addr = wrap(addr, n);
        b.data = d;
        wq.push_back(b);
        refmem[b.addr] = d;
        n++;
        if (n == len) begin
          dq.push_back(c + 2);
          busy_hi   = c + 2;
          idle_from = c + 3;
        end
      end
      j++;
      step();
    end
    bus.WR_VALID = 1'b0;
  endtask

  task automatic push_read(input int addr, input int len, input int c0);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.addr = wrap(addr, i);
      b.cyc  = c0 + 1 + i;
      b.data = '0;
      mrq.push_back(b);
      b.cyc  = c0 + 3 + i;
      b.data = refmem[b.addr];
      rq.push_back(b);
    end
    dq.push_back(c0 + len + 2);
    busy_lo   = c0;
    busy_hi   = c0 + len + 2;
    idle_from = c0 + len + 3;
  endtask

  task automatic read_burst(input int addr, input int len, output int c0);
    issue(1'b0, addr, len, c0);
    if (len == 0) begin
      dq.push_back(c0);
      idle_from = c0 + 1;
    end else begin
      push_read(addr, len, c0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, bus.REQ_READY, 0);
    chk({tag, "_busy"},      bus.BUSY, 0);
    chk({tag, "_done"},      bus.DONE, 0);
    chk({tag, "_mrd"},       bus.MRD, 0);
    chk({tag, "_mwr"},       bus.MWR, 0);
    chk({tag, "_data_oe"},   bus.DATA_OE, 0);
    chk({tag, "_rd_valid"},  bus.RD_VALID, 0);
    chk({tag, "_wr_ready"},  bus.WR_READY, 0);
    chk({tag, "_addr"},      bus.ADDR, 0);
    chk({tag, "_data_out"},  bus.DATA_OUT, 0);
    chk({tag, "_rd_data"},   bus.RD_DATA, 0);
  endtask

  task automatic release_reset();
    step();
    step();
    RST_N = 1'b1;
    chk("ready_low_before_first_edge", bus.REQ_READY, 0);
    step();
    chk("ready_after_release", bus.REQ_READY, 1);
    chk("done_after_release", bus.DONE, 0);
    idle_from = cyc;
    busy_lo   = 1;
    busy_hi   = 0;
    prev_addr = '0;
    prev_do   = '0;
    mon_en    = 1'b1;
  endtask

  initial begin
    int c0;
    bit w;
    int a, l, r;
    for (int i = 0; i < DEPTH; i++) refmem[i] = init_val(i);
    bus.REQ_VALID = 1'b0;
    bus.REQ_WRITE = 1'b0;
    bus.REQ_ADDR  = '0;
    bus.REQ_LEN   = '0;
    bus.WR_VALID  = 1'b0;
    bus.WR_DATA   = '0;

    // Power-on reset
    #2 RST_N = 1'b0;
    #1 check_reset_outputs("reset");
    release_reset();

    // Directed write / read-back at address 3
    write_burst(3, 4, 0);
    read_burst(3, 4, c0);

    // Address wrap 30,31,0
    write_burst(30, 3, 0);
    read_burst(30, 3, c0);

    // Stalled write: WR_VALID 1,0,0,1
    write_burst(12, 2, 2);
    read_burst(12, 2, c0);

    // Zero-length request
    write_burst(7, 0, 0);
    read_burst(9, 0, c0);

    // Request held during a burst is taken only after DONE
    wait_idle();
    chk("req_ready_at_held_issue", bus.REQ_READY, 1);
    bus.REQ_VALID = 1'b1;
    bus.REQ_WRITE = 1'b0;
    bus.REQ_ADDR  = ADDR_W'(5);
    bus.REQ_LEN   = (ADDR_W+1)'(3);
    step();
    c0 = cyc;
    push_read(5, 3, c0);
    bus.REQ_WRITE = 1'b1;
    bus.REQ_LEN   = '0;
    while (cyc < c0 + 7) step();
    dq.push_back(c0 + 7);
    idle_from     = c0 + 8;
    bus.REQ_VALID = 1'b0;

    // Randomized bursts
    for (int k = 0; k < 14; k++) begin
      w = 1'($urandom_range(0, 1));
      a = $urandom_range(0, DEPTH - 1);
      r = $urandom_range(0, 9);
      l = (r == 0) ? 0 : (r == 1) ? 32 : $urandom_range(1, 8);
      if (w) write_burst(a, l, 1);
      else   read_burst(a, l, c0);
    end

    // Reset in the second MRD cycle of a LEN=8 read
    read_burst(20, 8, c0);
    while (cyc < c0 + 2) step();
    chk("mrd_before_abort", bus.MRD, 1);
    #2 RST_N = 1'b0;
    mon_en = 1'b0;
    #1;
    chk("abort_mrd", bus.MRD, 0);
    chk("abort_rd_valid", bus.RD_VALID, 0);
    chk("abort_busy", bus.BUSY, 0);
    chk("abort_done", bus.DONE, 0);
    chk("abort_req_ready", bus.REQ_READY, 0);
    mrq.delete();
    rq.delete();
    dq.delete();
    wq.delete();
    release_reset();

    // Recovery after abort
    read_burst(20, 4, c0);
    write_burst(1, 5, 1);
    read_burst(0, 8, c0);

    wait_idle();
    step();
    chk("wq_drained", wq.size(), 0);
    chk("mrq_drained", mrq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    chk("dq_drained", dq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
